// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_pkg : shared types and constants for the display scheduler      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package disp_pkg;

  localparam int IDX_W  = 2;
  localparam int SRC_N  = 4;
  localparam int WORD_W = 32;

  localparam logic [31:0] DWELL_DEF = 32'd50_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    SHOW   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : first valid source searching upward (mod 4) from last+1     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick
  import disp_pkg::*;
(
  input  logic [SRC_N-1:0] valid,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] next,
  output logic             found
);

  logic [IDX_W-1:0] w_idx;

  // The final probe wraps back to 'last' itself, so a lone valid source reselects itself.
  always_comb begin
    next  = '0;
    found = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= SRC_N; k++) begin
      w_idx = last + IDX_W'(k);
      if (!found && valid[w_idx]) begin
        next  = w_idx;
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/disp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_sched : auto-rotating / manual source scheduler for a 7-seg disp |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module disp_sched
  import disp_pkg::*;
#(
  parameter logic [31:0] DWELL = DWELL_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SRC_N*WORD_W-1:0]   src_data,
  input  logic [SRC_N-1:0]          src_valid,
  input  logic                      mode,
  input  logic [IDX_W-1:0]          sel,
  input  logic                      freeze,
  output logic [WORD_W-1:0]         disp_x,
  output logic [IDX_W-1:0]          disp_src,
  output logic                      disp_valid,
  output logic                      sw_pulse
);

  localparam logic [31:0] c_DWELL_M1 = DWELL - 32'd1;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_disp_src;
  logic [WORD_W-1:0]   r_disp_x;
  logic [31:0]         r_cnt;
  logic                r_disp_valid, r_sw_pulse, r_mode;

  logic [IDX_W-1:0]    w_rr_next, w_pick;
  logic [WORD_W-1:0]   w_pick_word, w_cur_word;
  logic                w_rr_found, w_pick_ok, w_mode_chg, w_cur_ok, w_cnt_done;
  logic                w_take, w_show_upd, w_cnt_inc;

  rr_pick u_rr_pick (
    .valid (src_valid),
    .last  (r_disp_src),
    .next  (w_rr_next),
    .found (w_rr_found)
  );

  assign w_pick      = mode ? sel : w_rr_next;
  assign w_pick_ok   = mode ? src_valid[sel] : w_rr_found;
  assign w_pick_word = src_data[{w_pick, 5'd0} +: WORD_W];
  assign w_cur_word  = src_data[{r_disp_src, 5'd0} +: WORD_W];
  assign w_cur_ok    = src_valid[r_disp_src];
  assign w_mode_chg  = (mode != r_mode);
  assign w_cnt_done  = (r_cnt == c_DWELL_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_show_upd  = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_ok) w_state_nxt = SWITCH;
      end
      SWITCH: begin
        if (w_mode_chg) begin
          w_state_nxt = SWITCH;
        end else if (w_pick_ok) begin
          w_state_nxt = SHOW;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHOW: begin
        w_show_upd = !freeze;
        // Validity loss and mode change override freeze; dwell/sel changes do not.
        if (w_mode_chg || !w_cur_ok) begin
          w_state_nxt = SWITCH;
        end else if (!freeze) begin
          if (!mode) begin
            if (w_cnt_done) w_state_nxt = SWITCH;
            else            w_cnt_inc   = 1'b1;
          end else if (sel != r_disp_src) begin
            w_state_nxt = SWITCH;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp_src   <= IDX_W'(SRC_N - 1);
      r_disp_x     <= '0;
      r_disp_valid <= 1'b0;
      r_sw_pulse   <= 1'b0;
      r_cnt        <= '0;
      r_mode       <= 1'b0;
    end else begin
      r_mode     <= mode;
      r_sw_pulse <= w_take;
      if (w_take) begin
        r_disp_src   <= w_pick;
        r_disp_x     <= w_pick_word;
        r_disp_valid <= 1'b1;
      end else if (w_show_upd) begin
        r_disp_x <= w_cur_word;
      end else if (w_state_nxt == IDLE) begin
        r_disp_x     <= '0;
        r_disp_valid <= 1'b0;
      end
      if (r_state != SHOW) r_cnt <= '0;
      else if (w_cnt_inc)  r_cnt <= r_cnt + 32'd1;
    end
  end

  assign disp_x     = r_disp_x;
  assign disp_src   = r_disp_src;
  assign disp_valid = r_disp_valid;
  assign sw_pulse   = r_sw_pulse;

endmodule
`default_nettype wire

// File: tb/tb_disp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_disp_sched : scoreboard bench for disp_sched with DWELL=4          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_disp_sched;

  localparam int DW = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic [127:0] src_data  = '0;
  logic [3:0]   src_valid = 4'b0000;
  logic         mode      = 1'b0;
  logic [1:0]   sel       = 2'd0;
  logic         freeze    = 1'b0;
  logic [31:0]  disp_x;
  logic [1:0]   disp_src;
  logic         disp_valid, sw_pulse;

  typedef struct packed {
    logic [31:0] x;
    logic [1:0]  src;
    logic        v;
    logic        p;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // Reference model state: 0 idle, 1 switch, 2 show
  int          m_st   = 0;
  logic [1:0]  m_src  = 2'd3;
  logic [31:0] m_x    = '0;
  logic [31:0] m_cnt  = '0;
  logic        m_v    = 1'b0;
  logic        m_p    = 1'b0;
  logic        m_mode = 1'b0;
  logic        m_ok;
  logic [1:0]  m_idx;
  logic [2:0]  m_rr;

  disp_sched #(.DWELL(32'(DW))) u_dut (
    .clk        (clk),
    .rst        (rst),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .mode       (mode),
    .sel        (sel),
    .freeze     (freeze),
    .disp_x     (disp_x),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .sw_pulse   (sw_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] rr_ref(input logic [3:0] v, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (int'(last) + k) % 4;
      if (v[j]) return {1'b1, 2'(j)};
    end
    return 3'b000;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] d, input logic [1:0] i);
    return d[int'(i)*32 +: 32];
  endfunction

  // Model: one expected output set pushed per rising edge (or on async reset).
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_st = 0; m_src = 2'd3; m_x = '0; m_cnt = '0;
      m_v = 1'b0; m_p = 1'b0; m_mode = 1'b0;
      sb.delete();
    end else begin
      m_p  = 1'b0;
      m_rr = rr_ref(src_valid, m_src);
      m_ok  = mode ? src_valid[sel] : m_rr[2];
      m_idx = mode ? sel : m_rr[1:0];
      case (m_st)
        0: begin
          m_cnt = '0; m_x = '0; m_v = 1'b0;
          if (m_ok) m_st = 1;
        end
        1: begin
          m_cnt = '0;
          if (mode != m_mode) m_st = 1;
          else if (m_ok) begin
            m_st = 2; m_src = m_idx; m_x = word_of(src_data, m_idx); m_v = 1'b1; m_p = 1'b1;
          end else begin
            m_st = 0; m_x = '0; m_v = 1'b0;
          end
        end
        default: begin
          if (!freeze) m_x = word_of(src_data, m_src);
          if (mode != m_mode || !src_valid[m_src]) m_st = 1;
          else if (!freeze) begin
            if (!mode) begin
              if (m_cnt == 32'(DW - 1)) m_st = 1;
              else m_cnt = m_cnt + 32'd1;
            end else if (sel != m_src) m_st = 1;
          end
        end
      endcase
      m_mode = mode;
    end
    sb.push_back({m_x, m_src, m_v, m_p});
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    check_val("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("disp_x", disp_x, e.x);
      check_val("disp_src", 32'(disp_src), 32'(e.src));
      check_val("disp_valid", 32'(disp_valid), 32'(e.v));
      check_val("sw_pulse", 32'(sw_pulse), 32'(e.p));
    end
  end

  initial forever begin
    @(negedge clk);
    src_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_pulse(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sw_pulse && n < max_cyc);
    check_val("pulse_seen", 32'(sw_pulse), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_valid"}, 32'(disp_valid), 32'd0);
    check_val({tag, "_src"}, 32'(disp_src), 32'd3);
    check_val({tag, "_x"}, disp_x, 32'd0);
    check_val({tag, "_pulse"}, 32'(sw_pulse), 32'd0);
  endtask

  initial begin
    int n;
    int span;
    int pulses;
    src_valid = 4'b1010;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    #2 rst = 1'b1;

    // Auto rotation over sources 1 and 3
    wait_pulse(10, n);
    check_val("first_take_lat", 32'(n), 32'd2);
    check_val("rot_src_a", 32'(disp_src), 32'd1);
    wait_pulse(10, n);
    check_val("rot_period_a", 32'(n), 32'd5);
    check_val("rot_src_b", 32'(disp_src), 32'd3);
    wait_pulse(10, n);
    check_val("rot_period_b", 32'(n), 32'd5);
    check_val("rot_src_c", 32'(disp_src), 32'd1);

    // Validity loss mid-dwell, then everything invalid
    @(negedge clk);
    src_valid = 4'b1000;
    wait_pulse(10, n);
    check_val("drop_lat", 32'(n), 32'd2);
    check_val("drop_src", 32'(disp_src), 32'd3);
    src_valid = 4'b0000;
    repeat (3) @(negedge clk);
    check_val("idle_valid", 32'(disp_valid), 32'd0);
    check_val("idle_x", disp_x, 32'd0);

    // Manual mode hold, sel to an invalid source, then recovery
    mode = 1'b1; sel = 2'd2; src_valid = 4'b0100;
    wait_pulse(10, n);
    check_val("man_lat", 32'(n), 32'd2);
    check_val("man_src", 32'(disp_src), 32'd2);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sw_pulse) pulses++;
    end
    check_val("man_hold_pulses", 32'(pulses), 32'd0);
    check_val("man_hold_src", 32'(disp_src), 32'd2);
    sel = 2'd0;
    repeat (3) @(negedge clk);
    check_val("man_idle_valid", 32'(disp_valid), 32'd0);
    src_valid = 4'b0101;
    wait_pulse(10, n);
    check_val("man_src0", 32'(disp_src), 32'd0);

    // Back to auto, freeze mid-dwell for 10 cycles
    mode = 1'b0; src_valid = 4'b1111;
    wait_pulse(10, n);
    check_val("auto_back_lat", 32'(n), 32'd2);
    check_val("auto_back_src", 32'(disp_src), 32'd1);
    @(negedge clk);
    span = 1;
    freeze = 1'b1;
    repeat (10) begin
      @(negedge clk);
      span++;
    end
    check_val("frz_src", 32'(disp_src), 32'd1);
    freeze = 1'b0;
    wait_pulse(30, n);
    check_val("frz_span", 32'(span + n), 32'd15);
    check_val("frz_next_src", 32'(disp_src), 32'd2);

    // Asynchronous reset between edges during SHOW
    src_valid = 4'b0110;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outs("async_rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    wait_pulse(10, n);
    check_val("rel_lat", 32'(n), 32'd2);
    check_val("rel_src", 32'(disp_src), 32'd1);

    // Single valid source keeps reselecting itself
    src_valid = 4'b0001;
    wait_pulse(10, n);
    check_val("single_src", 32'(disp_src), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(10, n);
      check_val("single_period", 32'(n), 32'd5);
      check_val("single_src_hold", 32'(disp_src), 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
